// File: rtl/rv_isa_pkg.sv
// rv_isa_pkg: RV32I instruction-type codes, opcodes and encoder error codes shared by encoder and immediate generator
package rv_isa_pkg;
  localparam logic [3:0] T_LOAD  = 4'd0;
  localparam logic [3:0] T_IMM   = 4'd1;
  localparam logic [3:0] T_STORE = 4'd2;
  localparam logic [3:0] T_REG   = 4'd3;
  localparam logic [3:0] T_LUI   = 4'd4;
  localparam logic [3:0] T_AUIPC = 4'd5;
  localparam logic [3:0] T_BRNCH = 4'd6;
  localparam logic [3:0] T_JALR  = 4'd7;
  localparam logic [3:0] T_JAL   = 4'd8;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BRNCH = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [1:0] E_RANGE    = 2'd0;
  localparam logic [1:0] E_MISALIGN = 2'd1;
  localparam logic [1:0] E_BADTYPE  = 2'd2;
  function automatic logic [6:0] opcode_of(input logic [3:0] t);
    return t == T_LOAD  ? OP_LOAD  :
           t == T_IMM   ? OP_IMM   :
           t == T_STORE ? OP_STORE :
           t == T_REG   ? OP_REG   :
           t == T_LUI   ? OP_LUI   :
           t == T_AUIPC ? OP_AUIPC :
           t == T_BRNCH ? OP_BRNCH :
           t == T_JALR  ? OP_JALR  :
           t == T_JAL   ? OP_JAL   : 7'd0;
  endfunction
endpackage

// File: rtl/inst_field_pack.sv
// inst_field_pack: combinational RV32I encode + immediate range/alignment check
// Ports: in_type/in_rd/in_rs1/in_rs2/in_funct3/in_funct7/in_imm request fields;
//        word = encoded instruction, err = request rejected, code = reason (range/misaligned/bad type)
module inst_field_pack
  import rv_isa_pkg::*;
(
  input  logic [3:0]  in_type,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic [31:0] word,
  output logic        err,
  output logic [1:0]  code
);
  logic signed [31:0] s;
  logic [6:0] op;
  logic is_shift, i_bad, sh_bad, b_bad, j_bad, bad, mis, rng;
  assign s = in_imm;
  assign op = opcode_of(in_type);
  // funct3 001 (slli) and 101 (srli/srai) carry a 5-bit shamt instead of a 12-bit immediate
  assign is_shift = in_type == T_IMM && in_funct3[1:0] == 2'b01;
  assign i_bad  = s < -32'sd2048 || s > 32'sd2047;
  assign sh_bad = in_imm > 32'd31;
  assign b_bad  = s < -32'sd4096 || s > 32'sd4094;
  assign j_bad  = s < -32'sd1048576 || s > 32'sd1048574;
  always_comb begin
    word = '0;
    bad  = 1'b0;
    mis  = 1'b0;
    rng  = 1'b0;
    case (in_type)
      T_LOAD, T_JALR: begin
        word = {in_imm[11:0], in_rs1, in_type == T_JALR ? 3'b000 : in_funct3, in_rd, op};
        rng  = i_bad;
      end
      T_IMM: begin
        word = is_shift ? {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, op}
                        : {in_imm[11:0], in_rs1, in_funct3, in_rd, op};
        rng  = is_shift ? sh_bad : i_bad;
      end
      T_STORE: begin
        word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], op};
        rng  = i_bad;
      end
      T_REG: word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, op};
      T_LUI, T_AUIPC: begin
        word = {in_imm[31:12], in_rd, op};
        mis  = |in_imm[11:0];
      end
      T_BRNCH: begin
        word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], op};
        mis  = in_imm[0];
        rng  = b_bad;
      end
      T_JAL: begin
        word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, op};
        mis  = in_imm[0];
        rng  = j_bad;
      end
      default: bad = 1'b1;
    endcase
  end
  assign err  = bad || mis || rng;
  assign code = bad ? E_BADTYPE : mis ? E_MISALIGN : E_RANGE;
endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: encodes decoded requests into RV32I words and emits them with sequential addresses
// Ports: clk/reset (sync, active-high); in_valid/in_ready + in_* request fields;
//        out_valid/out_ready + out_inst/out_addr emitted word; err_valid/err_code rejection report;
//        count = words emitted since reset; full = address space exhausted
module inst_encoder
  import rv_isa_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_type,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count,
  output logic              full
);
  localparam logic [ADDR_W:0] START = (ADDR_W+1)'(BASE);
  localparam logic [ADDR_W:0] END   = {1'b1, {ADDR_W{1'b0}}};
  logic [31:0] word;
  logic perr;
  logic [1:0] pcode;
  logic acc, push, pop;
  logic in_ready_q, in_ready_d;
  logic out_valid_q, out_valid_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic skid_valid_q, skid_valid_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;
  logic [ADDR_W:0] alloc_q, alloc_d;
  logic [ADDR_W:0] count_q, count_d;
  logic full_q, full_d;
  logic err_valid_q, err_valid_d;
  logic [1:0] err_code_q, err_code_d;
  inst_field_pack u_pack (
    .in_type   (in_type),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .word      (word),
    .err       (perr),
    .code      (pcode)
  );
  assign acc  = in_valid && in_ready_q;
  assign push = acc && !perr;
  assign pop  = out_valid_q && out_ready;
  // alloc_q is the address the next accepted word will carry; it runs ahead of
  // count by the number of buffered words so addresses stay consecutive.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_inst_d   = out_inst_q;
    out_addr_d   = out_addr_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_addr_d  = skid_addr_q;
    if (pop || !out_valid_q) begin
      out_valid_d  = skid_valid_q || push;
      out_inst_d   = skid_valid_q ? skid_inst_q : push ? word : out_inst_q;
      out_addr_d   = skid_valid_q ? skid_addr_q : push ? alloc_q[ADDR_W-1:0] : out_addr_q;
      skid_valid_d = skid_valid_q && push;
      skid_inst_d  = skid_valid_q && push ? word : skid_inst_q;
      skid_addr_d  = skid_valid_q && push ? alloc_q[ADDR_W-1:0] : skid_addr_q;
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_inst_d  = word;
      skid_addr_d  = alloc_q[ADDR_W-1:0];
    end
    alloc_d     = alloc_q + {{ADDR_W{1'b0}}, push};
    count_d     = count_q + {{ADDR_W{1'b0}}, pop};
    full_d      = full_q || (pop && &out_addr_q);
    // once the last address is handed out no further word may be accepted
    in_ready_d  = !skid_valid_d && alloc_d != END && !full_d;
    err_valid_d = acc && perr;
    err_code_d  = err_valid_d ? pcode : err_code_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_inst_q   <= '0;
      out_addr_q   <= START[ADDR_W-1:0];
      skid_valid_q <= 1'b0;
      skid_inst_q  <= '0;
      skid_addr_q  <= '0;
      alloc_q      <= START;
      count_q      <= '0;
      full_q       <= 1'b0;
      err_valid_q  <= 1'b0;
      err_code_q   <= '0;
    end else begin
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_inst_q   <= out_inst_d;
      out_addr_q   <= out_addr_d;
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_addr_q  <= skid_addr_d;
      alloc_q      <= alloc_d;
      count_q      <= count_d;
      full_q       <= full_d;
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_addr  = out_addr_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign count     = count_q;
  assign full      = full_q;
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: randomized + directed bench with a behavioural encoder/queue model
module tb_inst_encoder;
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset = 1;
  logic in_valid = 0, out_ready = 0, in_valid2 = 0;
  logic [3:0] in_type = 0;
  logic [4:0] in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic [2:0] in_funct3 = 0;
  logic [6:0] in_funct7 = 0;
  logic [31:0] in_imm = 0;
  logic in_ready, out_valid, err_valid, full;
  logic [31:0] out_inst;
  logic [9:0] out_addr;
  logic [1:0] err_code;
  logic [10:0] count;
  logic in_ready2, out_valid2, err_valid2, full2;
  logic [31:0] out_inst2;
  logic [1:0] out_addr2, err_code2;
  logic [2:0] count2;

  inst_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
    .err_valid(err_valid), .err_code(err_code), .count(count), .full(full)
  );

  inst_encoder #(.ADDR_W(2), .BASE(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_type(in_type), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid2), .out_ready(1'b1), .out_inst(out_inst2), .out_addr(out_addr2),
    .err_valid(err_valid2), .err_code(err_code2), .count(count2), .full(full2)
  );

  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {logic err; logic [1:0] code; logic [31:0] w;} enc_t;
  typedef struct packed {logic [9:0] a; logic [31:0] w;} ent_t;

  function automatic logic [31:0] opc(input logic [3:0] t);
    case (t)
      0: return 32'h03; 1: return 32'h13; 2: return 32'h23;
      3: return 32'h33; 4: return 32'h37; 5: return 32'h17;
      6: return 32'h63; 7: return 32'h67; default: return 32'h6F;
    endcase
  endfunction

  // Builds the word by OR-ing each field into its bit position, then applies the range rules.
  function automatic enc_t model(input logic [3:0] t, input logic [31:0] rd, rs1, rs2, f3, f7, imm);
    enc_t e = '0;
    longint s = $signed(imm);
    longint lo = 0, hi = 0;
    bit has_rng = 0, mis = 0;
    logic [31:0] op = opc(t);
    if (t > 8) begin
      e.err = 1; e.code = 2;
      return e;
    end
    case (t)
      0, 7: begin
        e.w = op | rd << 7 | (t == 7 ? 0 : f3) << 12 | rs1 << 15 | (imm & 32'hfff) << 20;
        has_rng = 1; lo = -2048; hi = 2047;
      end
      1: if (f3 == 1 || f3 == 5) begin
        e.w = op | rd << 7 | f3 << 12 | rs1 << 15 | (imm & 31) << 20 | f7 << 25;
        has_rng = 1; lo = 0; hi = 31;
      end else begin
        e.w = op | rd << 7 | f3 << 12 | rs1 << 15 | (imm & 32'hfff) << 20;
        has_rng = 1; lo = -2048; hi = 2047;
      end
      2: begin
        e.w = op | (imm & 31) << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | ((imm >> 5) & 127) << 25;
        has_rng = 1; lo = -2048; hi = 2047;
      end
      3: e.w = op | rd << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | f7 << 25;
      4, 5: begin
        e.w = op | rd << 7 | (imm & 32'hfffff000);
        mis = (imm & 32'hfff) != 0;
      end
      6: begin
        e.w = op | ((imm >> 11) & 1) << 7 | ((imm >> 1) & 15) << 8 | f3 << 12 | rs1 << 15 |
              rs2 << 20 | ((imm >> 5) & 63) << 25 | ((imm >> 12) & 1) << 31;
        mis = imm[0]; has_rng = 1; lo = -4096; hi = 4094;
      end
      default: begin
        e.w = op | rd << 7 | ((imm >> 12) & 255) << 12 | ((imm >> 11) & 1) << 20 |
              ((imm >> 1) & 1023) << 21 | ((imm >> 20) & 1) << 31;
        mis = imm[0]; has_rng = 1; lo = -(64'sd1 << 20); hi = (64'sd1 << 20) - 2;
      end
    endcase
    if (mis) begin e.err = 1; e.code = 1; end
    else if (has_rng && (s < lo || s > hi)) begin e.err = 1; e.code = 0; end
    return e;
  endfunction

  ent_t q[$];
  int next_addr = 0, emitted = 0;
  bit pend = 0;
  logic [1:0] last_code = 0;
  enc_t me;

  always @(negedge clk) begin
    if (reset) begin
      q.delete(); next_addr = 0; emitted = 0; pend = 0; last_code = 0;
    end else begin
      chk("out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) begin
        chk("out_inst", out_inst, q[0].w);
        chk("out_addr", out_addr, q[0].a);
      end
      chk("in_ready", in_ready, q.size() < 2 && next_addr < 1024);
      chk("err_valid", err_valid, pend);
      chk("err_code", err_code, last_code);
      chk("count", count, emitted);
      chk("full", full, emitted >= 1024);
      if (out_valid && out_ready && q.size() > 0) begin
        void'(q.pop_front());
        emitted++;
      end
      pend = 0;
      if (in_valid && in_ready) begin
        me = model(in_type, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
        if (me.err) begin
          pend = 1; last_code = me.code;
        end else begin
          q.push_back('{a: 10'(next_addr), w: me.w});
          next_addr++;
        end
      end
    end
  end

  task automatic set_req(input int t, rd, rs1, rs2, f3, f7, input logic [31:0] imm);
    in_type = 4'(t); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
    in_funct3 = 3'(f3); in_funct7 = 7'(f7); in_imm = imm;
  endtask

  task automatic wait_accept();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    in_valid = 0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic send(input int t, rd, rs1, rs2, f3, f7, input logic [31:0] imm);
    @(posedge clk); #1;
    set_req(t, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1;
    wait_accept();
  endtask

  int edges [14] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4096, -4098, 31, 32, 0,
                     (1 << 20) - 2, -(1 << 20), 1 << 20};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc2 = 0, n2 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_err_valid", err_valid, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst2_out_addr", out_addr2, 2);
    chk("rst2_in_ready", in_ready2, 1);
    @(posedge clk); #1;
    reset = 0;
    set_req(3, 1, 2, 3, 0, 7'h20, 32'hdeadbeef);
    in_valid2 = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid2) begin
        chk("full_addr", out_addr2, 2 + n2);
        chk("full_inst", out_inst2, 32'h403100B3);
        n2++;
      end
      if (in_ready2) acc2++;
    end
    @(posedge clk); #1;
    in_valid2 = 0;
    @(negedge clk);
    chk("full_accepts", acc2, 2);
    chk("full_emitted", n2, 2);
    chk("full_flag", full2, 1);
    chk("full_in_ready", in_ready2, 0);
    chk("full_count", count2, 2);

    out_ready = 1;
    send(1, 1, 0, 0, 0, 0, 32'hFFFFFFFF);
    @(negedge clk); chk("lit_addi", out_inst, 32'hFFF00093); chk("lit_addi_addr", out_addr, 0);
    send(2, 0, 1, 2, 2, 0, 4);
    @(negedge clk); chk("lit_sw", out_inst, 32'h0020A223); chk("lit_sw_addr", out_addr, 1);
    send(6, 0, 0, 0, 0, 0, -4);
    @(negedge clk); chk("lit_beq", out_inst, 32'hFE000EE3); chk("lit_beq_addr", out_addr, 2);
    send(8, 1, 0, 0, 0, 0, 8);
    @(negedge clk); chk("lit_jal", out_inst, 32'h008000EF);
    send(4, 5, 0, 0, 0, 0, 32'h12345000);
    @(negedge clk); chk("lit_lui", out_inst, 32'h123452B7); chk("lit_lui_addr", out_addr, 4);
    send(6, 0, 0, 0, 0, 0, 3);
    @(negedge clk);
    chk("mis_pulse", err_valid, 1); chk("mis_code", err_code, 1);
    chk("mis_no_out", out_valid, 0); chk("mis_count", count, 5);
    @(negedge clk); chk("mis_pulse_end", err_valid, 0);
    send(1, 1, 0, 0, 0, 0, 2048);
    @(negedge clk); chk("rng_pulse", err_valid, 1); chk("rng_code", err_code, 0);
    send(9, 1, 0, 0, 0, 0, 0);
    @(negedge clk); chk("bad_pulse", err_valid, 1); chk("bad_code", err_code, 2);
    @(negedge clk); chk("bad_pulse_end", err_valid, 0); chk("bad_count", count, 5);

    @(posedge clk); #1;
    out_ready = 0;
    set_req(1, 1, 0, 0, 0, 0, 1);
    in_valid = 1;
    @(posedge clk); #1; in_imm = 2;
    @(posedge clk); #1; in_imm = 3;
    @(negedge clk);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_inst", out_inst, 32'h00100093);
    chk("stall_addr", out_addr, 5);
    repeat (3) begin
      @(negedge clk);
      chk("stall_hold", out_inst, 32'h00100093);
    end
    @(posedge clk); #1;
    out_ready = 1;
    wait_accept();

    for (int i = 0; i < 600; i++) begin
      logic [31:0] imm;
      @(posedge clk); #1;
      case ($urandom_range(0, 3))
        0: imm = 32'($signed($urandom_range(0, 16)) - 8);
        1: imm = $urandom;
        2: imm = edges[$urandom_range(0, 13)];
        default: imm = $urandom & 32'hFFFFF000;
      endcase
      set_req($urandom_range(0, 20) == 0 ? 15 : $urandom_range(0, 9), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 7),
              $urandom_range(0, 127), imm);
      in_valid = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 7;
    end
    @(posedge clk); #1;
    in_valid = 0;
    out_ready = 1;
    repeat (5) @(posedge clk);

    #1 out_ready = 0;
    send(1, 2, 0, 0, 0, 0, 7);
    send(1, 3, 0, 0, 0, 0, 9);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_inst", out_inst, 0);
    chk("mid_rst_out_addr", out_addr, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_err_valid", err_valid, 0);
    chk("mid_rst_err_code", err_code, 0);
    chk("mid_rst_full", full, 0);
    out_ready = 1;
    send(1, 1, 0, 0, 0, 0, 5);
    @(negedge clk);
    chk("post_rst_inst", out_inst, 32'h00500093);
    chk("post_rst_addr", out_addr, 0);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
